// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and bus-slicing helper for the multi-port register file
package regfile_pkg;

  localparam int RF_DWIDTH = 32;
  localparam int RF_AWIDTH = 5;
  localparam int RF_DEPTH  = 32;
  localparam int REG_ZERO  = 0;

  // Widest flattened bus and widest single field the slicing helper handles
  localparam int RF_BUS_MAX   = 1024;
  localparam int RF_SLICE_MAX = 64;

  // Field idx of width w from a flattened bus; callers truncate to the real field width
  function automatic logic [RF_SLICE_MAX-1:0] get_slice(input logic [RF_BUS_MAX-1:0] bus,
                                                        input int idx, input int w);
    logic [RF_BUS_MAX-1:0] sh;
    sh = bus >> (idx * w);
    return sh[RF_SLICE_MAX-1:0] & ((RF_SLICE_MAX'(1) << w) - RF_SLICE_MAX'(1));
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one read port: write-through bypass data and next-state pending bit
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DWIDTH = RF_DWIDTH,
  parameter int AWIDTH = RF_AWIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NWRITE = 2
) (
  input  logic [AWIDTH-1:0]        ra_i,
  input  logic [DWIDTH-1:0]        stored_i,
  input  logic [NWRITE-1:0]        we_eff_i,
  input  logic [NWRITE*AWIDTH-1:0] wa_i,
  input  logic [NWRITE*DWIDTH-1:0] wd_i,
  input  logic [NWRITE-1:0]        wclr_i,
  input  logic                     set_eff_i,
  input  logic [AWIDTH-1:0]        set_addr_i,
  input  logic [DEPTH-1:0]         busy_i,
  output logic [DWIDTH-1:0]        rd_o,
  output logic                     busy_o
);

  localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   DEPTH_A = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] ZERO_A  = AWIDTH'(REG_ZERO);

  // Later (higher-index) matching writes override earlier ones; a set overrides any clear
  always_comb begin
    rd_o   = '0;
    busy_o = 1'b0;
    if (ra_i != ZERO_A && {1'b0, ra_i} < DEPTH_A) begin
      rd_o   = stored_i;
      busy_o = busy_i[ra_i[IW-1:0]];
      for (int i = 0; i < NWRITE; i++) begin
        if (we_eff_i[i] && AWIDTH'(get_slice(RF_BUS_MAX'(wa_i), i, AWIDTH)) == ra_i) begin
          rd_o = DWIDTH'(get_slice(RF_BUS_MAX'(wd_i), i, DWIDTH));
          if (wclr_i[i]) busy_o = 1'b0;
        end
      end
      if (set_eff_i && set_addr_i == ra_i) busy_o = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with registered bypassed reads and pending scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DWIDTH = RF_DWIDTH,
  parameter int AWIDTH = RF_AWIDTH,
  parameter int DEPTH  = RF_DEPTH,
  parameter int NREAD  = 3,
  parameter int NWRITE = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic [NWRITE-1:0]        we,
  input  logic [NWRITE*AWIDTH-1:0] wa,
  input  logic [NWRITE*DWIDTH-1:0] wd,
  input  logic [NWRITE-1:0]        wclr,
  input  logic                     set_en,
  input  logic [AWIDTH-1:0]        set_addr,
  input  logic [NREAD*AWIDTH-1:0]  ra,
  output logic [NREAD*DWIDTH-1:0]  rd,
  output logic [NREAD-1:0]         rd_busy,
  output logic [DEPTH-1:0]         busy_vec
);

  localparam int                IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AWIDTH:0]   DEPTH_A = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] ZERO_A  = AWIDTH'(REG_ZERO);

  logic [DWIDTH-1:0]        mem_q [DEPTH];
  logic [DWIDTH-1:0]        mem_d [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NREAD*DWIDTH-1:0]  rd_q, rd_d;
  logic [NREAD-1:0]         rdb_q, rdb_d;
  logic [NWRITE-1:0]        we_eff;
  logic [AWIDTH-1:0]        wa_a [NWRITE];
  logic [DWIDTH-1:0]        wd_a [NWRITE];
  logic                     set_eff;

  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    return (a != ZERO_A) && ({1'b0, a} < DEPTH_A);
  endfunction

  // Qualify writes and sets: x0, out-of-range targets and stalled cycles never take effect
  always_comb begin
    for (int i = 0; i < NWRITE; i++) begin
      wa_a[i]   = AWIDTH'(get_slice(RF_BUS_MAX'(wa), i, AWIDTH));
      wd_a[i]   = DWIDTH'(get_slice(RF_BUS_MAX'(wd), i, DWIDTH));
      we_eff[i] = we[i] && addr_ok(wa_a[i]) && !stall;
    end
    set_eff = set_en && addr_ok(set_addr) && !stall;
  end

  // Storage next state: ascending port order so the highest-index writer lands last
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < NWRITE; i++) begin
      if (we_eff[i]) mem_d[wa_a[i][IW-1:0]] = wd_a[i];
    end
  end

  // Scoreboard next state: clears first, then a set so a new producer wins over a retiring one
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NWRITE; i++) begin
      if (we_eff[i] && wclr[i]) busy_d[wa_a[i][IW-1:0]] = 1'b0;
    end
    if (set_eff) busy_d[set_addr[IW-1:0]] = 1'b1;
    busy_d[0] = 1'b0;
  end

  for (genvar j = 0; j < NREAD; j++) begin : g_rd
    logic [AWIDTH-1:0] ra_j;
    assign ra_j = ra[j*AWIDTH +: AWIDTH];

    regfile_rd_port #(
      .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH), .NWRITE(NWRITE)
    ) u_rd (
      .ra_i      (ra_j),
      .stored_i  (mem_q[ra_j[IW-1:0]]),
      .we_eff_i  (we_eff),
      .wa_i      (wa),
      .wd_i      (wd),
      .wclr_i    (wclr),
      .set_eff_i (set_eff),
      .set_addr_i(set_addr),
      .busy_i    (busy_q),
      .rd_o      (rd_d[j*DWIDTH +: DWIDTH]),
      .busy_o    (rdb_d[j])
    );
  end

  // All state frozen on stall; reset drops every in-flight write and pending bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      busy_q <= '0;
      rd_q   <= '0;
      rdb_q  <= '0;
    end else if (!stall) begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      rd_q   <= rd_d;
      rdb_q  <= rdb_d;
    end
  end

  assign rd       = rd_q;
  assign rd_busy  = rdb_q;
  assign busy_vec = busy_q;

  a_x0_zero:  assert property (@(posedge clk) disable iff (!rst_n) mem_q[0] == '0);
  a_busy0:    assert property (@(posedge clk) disable iff (!rst_n) !busy_q[0]);
  a_rd_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(rd_q));

endmodule
